// File: rtl/sa_pkg.sv
// Shared types and default geometry for the systolic-array operand feeder.
package sa_pkg;

  localparam int SA_HPE     = 64;
  localparam int SA_VPE     = 64;
  localparam int SA_WIDTH   = 32;
  localparam int SA_PRE_LAT = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } sa_state_e;

  // Cycles of zero input needed so the last operand reaches the far corner PE.
  function automatic int flush_len(input int hpe, input int vpe, input int pre_lat);
    return hpe + vpe - 2 + pre_lat;
  endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Fixed-depth, zero-reset shift register delaying one operand lane.
module sa_skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr_q [DEPTH];
  logic [WIDTH-1:0] sr_d [DEPTH];

  always_comb begin
    sr_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_n) sr_q[i] <= '0;
      else        sr_q[i] <= sr_d[i];
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// Tile sequencer plus per-lane skew lines: lane z of an accepted vector reaches
// the array z+1 cycles later, then zeros are flushed until results are final.
module sa_skew_feeder
  import sa_pkg::*;
#(
  parameter int HPE     = SA_HPE,
  parameter int VPE     = SA_VPE,
  parameter int WIDTH   = SA_WIDTH,
  parameter int PRE_LAT = SA_PRE_LAT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [15:0]          k_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH*HPE-1:0] a_vec,
  input  logic [WIDTH*HPE-1:0] b_vec,
  output logic [WIDTH*HPE-1:0] AA,
  output logic [WIDTH*HPE-1:0] BB,
  output logic                 acc_clr,
  output logic                 busy,
  output logic                 done
);

  localparam int FLUSH_LEN = flush_len(HPE, VPE, PRE_LAT);
  localparam int FCW       = $clog2(HPE + VPE + PRE_LAT);
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_LEN - 1);

  sa_state_e      state_q, state_d;
  logic [15:0]    klen_q, klen_d;
  logic [15:0]    acc_cnt_q, acc_cnt_d;
  logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
  logic           accept;

  assign accept = (state_q == ST_FEED) && in_valid;

  always_comb begin
    state_d     = state_q;
    klen_d      = klen_q;
    acc_cnt_d   = acc_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (k_len != 16'd0)) begin
          state_d = ST_CLEAR;
          klen_d  = k_len;
        end
      end
      ST_CLEAR: begin
        acc_cnt_d = '0;
        state_d   = ST_FEED;
      end
      ST_FEED: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + 16'd1;
          if (acc_cnt_q == klen_q - 16'd1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) state_d = ST_DONE;
        else                           flush_cnt_d = flush_cnt_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      klen_q      <= '0;
      acc_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      klen_q      <= klen_d;
      acc_cnt_q   <= acc_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign in_ready = (state_q == ST_FEED);
  assign acc_clr  = (state_q == ST_CLEAR);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

  // Skew lines shift every cycle; anything but an accepted vector enters as zero.
  logic [WIDTH*HPE-1:0] a_push, b_push;
  assign a_push = accept ? a_vec : '0;
  assign b_push = accept ? b_vec : '0;

  for (genvar z = 0; z < HPE; z++) begin : g_lane
    sa_skew_line #(.DEPTH(z + 1), .WIDTH(WIDTH)) u_skew_a (
      .clk  (CLK),
      .rst_n(RST),
      .din  (a_push[z*WIDTH +: WIDTH]),
      .dout (AA[z*WIDTH +: WIDTH])
    );
    sa_skew_line #(.DEPTH(z + 1), .WIDTH(WIDTH)) u_skew_b (
      .clk  (CLK),
      .rst_n(RST),
      .din  (b_push[z*WIDTH +: WIDTH]),
      .dout (BB[z*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Scoreboard bench for sa_skew_feeder with a 4x4 array geometry.
module tb_sa_skew_feeder;

  localparam int HPE   = 4;
  localparam int VPE   = 4;
  localparam int W     = 32;
  localparam int PRE   = 1;
  localparam int FLUSH = HPE + VPE - 2 + PRE;

  logic             CLK;
  logic             RST;
  logic             start;
  logic [15:0]      k_len;
  logic             in_valid;
  logic             in_ready;
  logic [W*HPE-1:0] a_vec;
  logic [W*HPE-1:0] b_vec;
  logic [W*HPE-1:0] AA;
  logic [W*HPE-1:0] BB;
  logic             acc_clr;
  logic             busy;
  logic             done;

  sa_skew_feeder #(.HPE(HPE), .VPE(VPE), .WIDTH(W), .PRE_LAT(PRE)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .k_len   (k_len),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a_vec   (a_vec),
    .b_vec   (b_vec),
    .AA      (AA),
    .BB      (BB),
    .acc_clr (acc_clr),
    .busy    (busy),
    .done    (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int         cyc;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } sb_t;

  sb_t sb_q [HPE][$];

  function automatic logic [W-1:0] lane_a(input int n, input int z);
    return W'(32'h100 * n + z);
  endfunction

  function automatic logic [W-1:0] lane_b(input int n, input int z);
    return lane_a(n, z) ^ 32'hB000_0000;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Skewed data monitor: every cycle each lane must carry its scheduled value or zero.
  logic [W*HPE-1:0] exp_a, exp_b;
  sb_t              e_m;
  always @(negedge CLK) begin
    if (mon_en) begin
      exp_a = '0;
      exp_b = '0;
      for (int z = 0; z < HPE; z++) begin
        if (sb_q[z].size() > 0 && sb_q[z][0].cyc == cyc) begin
          e_m = sb_q[z].pop_front();
          exp_a[z*W +: W] = e_m.a;
          exp_b[z*W +: W] = e_m.b;
        end
      end
      total++;
      if (AA !== exp_a || BB !== exp_b) begin
        bad++;
        $display("FAIL skew_data cyc=%0d AA=%h BB=%h expected AA=%h BB=%h", cyc, AA, BB, exp_a, exp_b);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic run_tile(input int k, input int gap_after, input int gap_len, input bit poke,
                          input int abort_at, input bit lane_chk, input string tag);
    int  s, n, gap_left, a0, exp_done, dcnt0, left;
    bit  seen_done;
    sb_t e;
    dcnt0    = done_cnt;
    s        = cyc;
    start    = 1'b1;
    k_len    = 16'(k);
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    total++;
    if (acc_clr !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s clear_cycle acc_clr=%b busy=%b in_ready=%b expected 1 1 0", tag, acc_clr, busy, in_ready);
    end
    n         = 0;
    gap_left  = gap_len;
    a0        = -100;
    seen_done = 1'b0;
    exp_done  = s + 1 + k + gap_len + FLUSH + 1;
    tick();
    for (int i = 0; i < 200 && !seen_done; i++) begin
      if (abort_at > 0 && cyc == s + abort_at) begin
        RST = 1'b0;
        tick();
        for (int z = 0; z < HPE; z++) sb_q[z].delete();
        total++;
        if (AA !== '0 || BB !== '0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
          bad++;
          $display("FAIL %s abort_reset AA=%h BB=%h busy=%b in_ready=%b done=%b expected all zero", tag, AA, BB, busy, in_ready, done);
        end
        RST = 1'b1;
        repeat (4) begin
          tick();
          total++;
          if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s abort_idle done=%b busy=%b expected 0 0", tag, done, busy);
          end
        end
        total++;
        if (done_cnt !== dcnt0) begin
          bad++;
          $display("FAIL %s abort_no_done done_count=%0d expected %0d", tag, done_cnt, dcnt0);
        end
        return;
      end
      start = (poke && i == 1);
      if (n < k) begin
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("FAIL %s feed_ready cyc=%0d in_ready=%b expected 1", tag, cyc, in_ready);
        end
        if (n == gap_after && gap_left > 0) begin
          in_valid = 1'b0;
          a_vec    = {HPE{32'hDEAD_BEEF}};
          b_vec    = ~a_vec;
          gap_left--;
        end else begin
          in_valid = 1'b1;
          for (int z = 0; z < HPE; z++) begin
            a_vec[z*W +: W] = lane_a(n, z);
            b_vec[z*W +: W] = lane_b(n, z);
            e.cyc = cyc + 1 + z;
            e.a   = lane_a(n, z);
            e.b   = lane_b(n, z);
            sb_q[z].push_back(e);
          end
          if (n == 0) a0 = cyc;
          n++;
        end
      end else begin
        in_valid = 1'b0;
        a_vec    = '0;
        b_vec    = '0;
        if (done === 1'b1) begin
          seen_done = 1'b1;
          total++;
          if (cyc !== exp_done) begin
            bad++;
            $display("FAIL %s done_cycle got=%0d expected=%0d", tag, cyc - s, exp_done - s);
          end
        end else begin
          total++;
          if (in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s flush_ctrl cyc=%0d in_ready=%b busy=%b expected 0 1", tag, cyc, in_ready, busy);
          end
        end
      end
      if (lane_chk && cyc == a0 + 3) begin
        total++;
        if (AA[2*W +: W] !== lane_a(0, 2) || BB[2*W +: W] !== lane_b(0, 2)) begin
          bad++;
          $display("FAIL %s lane2_delay AA2=%h BB2=%h expected %h %h", tag, AA[2*W +: W], BB[2*W +: W], lane_a(0, 2), lane_b(0, 2));
        end
      end
      if (!seen_done) tick();
    end
    if (!seen_done) begin
      total++;
      bad++;
      $display("FAIL %s done_timeout no done within bound", tag);
      in_valid = 1'b0;
      return;
    end
    start = poke;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || acc_clr !== 1'b0) begin
      bad++;
      $display("FAIL %s after_done busy=%b done=%b acc_clr=%b expected 0 0 0", tag, busy, done, acc_clr);
    end
    repeat (2) tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_after busy=%b expected 0", tag, busy);
    end
    total++;
    if (done_cnt !== dcnt0 + 1) begin
      bad++;
      $display("FAIL %s done_count got=%0d expected=%0d", tag, done_cnt - dcnt0, 1);
    end
    left = 0;
    for (int z = 0; z < HPE; z++) left += sb_q[z].size();
    total++;
    if (left !== 0) begin
      bad++;
      $display("FAIL %s sb_drain pending=%0d expected 0", tag, left);
    end
  endtask

  task automatic test_reset();
    repeat (10) begin
      tick();
      total++;
      if (AA !== '0 || BB !== '0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || acc_clr !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle AA=%h BB=%h busy=%b in_ready=%b done=%b acc_clr=%b expected all zero", AA, BB, busy, in_ready, done, acc_clr);
      end
    end
  endtask

  task automatic test_basic();
    run_tile(3, 0, 0, 1'b0, 0, 1'b1, "basic");
  endtask

  task automatic test_gap();
    run_tile(3, 1, 2, 1'b0, 0, 1'b0, "gap");
  endtask

  task automatic test_klen_zero();
    start = 1'b1;
    k_len = 16'd0;
    tick();
    start = 1'b0;
    repeat (3) begin
      total++;
      if (busy !== 1'b0 || acc_clr !== 1'b0) begin
        bad++;
        $display("FAIL klen_zero busy=%b acc_clr=%b expected 0 0", busy, acc_clr);
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    run_tile(3, 0, 0, 1'b1, 0, 1'b0, "start_ignored");
  endtask

  task automatic test_reset_flush();
    run_tile(3, 0, 0, 1'b0, 6, 1'b0, "reset_flush");
    run_tile(3, 0, 0, 1'b0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_tile(5, 2, 1, 1'b0, 0, 1'b0, "b2b_a");
    run_tile(2, 0, 0, 1'b0, 0, 1'b0, "b2b_b");
  endtask

  initial begin
    RST      = 1'b0;
    start    = 1'b0;
    k_len    = '0;
    in_valid = 1'b0;
    a_vec    = '0;
    b_vec    = '0;
    repeat (3) tick();
    mon_en = 1'b1;
    RST    = 1'b1;
    test_reset();
    test_basic();
    test_gap();
    test_klen_zero();
    test_start_ignored();
    test_reset_flush();
    test_back_to_back();
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
